// File: rtl/router_pkg.sv
// Shared port numbering, sizes and types for the parameterised 2-D mesh router.
package router_pkg;
    localparam int NUM_PORTS      = 5;
    localparam int PORT_W         = 3;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH = 8;

    typedef enum logic [PORT_W-1:0] {
        PORT_LOCAL = 3'd0,
        PORT_EAST  = 3'd1,
        PORT_WEST  = 3'd2,
        PORT_NORTH = 3'd3,
        PORT_SOUTH = 3'd4
    } port_e;
endpackage

// File: rtl/router_mesh_param_if.sv
// Flit-level connection of the mesh router; every bus is flattened with port p at slice p.
interface router_mesh_param_if
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [NUM_PORTS*DATA_WIDTH-1:0] in_data;
    logic [NUM_PORTS-1:0]            in_valid;
    logic [NUM_PORTS-1:0]            in_full;
    logic [NUM_PORTS*DATA_WIDTH-1:0] out_data;
    logic [NUM_PORTS-1:0]            out_valid;
    logic [NUM_PORTS-1:0]            out_full;
    logic                            err_misroute;

    modport master (
        output in_data, in_valid, out_full,
        input  in_full, out_data, out_valid, err_misroute
    );

    modport slave (
        input  in_data, in_valid, out_full,
        output in_full, out_data, out_valid, err_misroute
    );
endinterface

// File: rtl/router_mesh_param_rr_arbiter.sv
// Five-way round-robin arbiter; the requester after the last winner has top priority.
module rr_arbiter
    import router_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 advance,
    output logic [NUM_PORTS-1:0] gnt
);
    localparam int SUM_W = PORT_W + 1;

    logic [PORT_W-1:0] last_r;
    logic [PORT_W-1:0] win_s;
    logic [PORT_W-1:0] idx_s;
    logic [SUM_W-1:0]  sum_s;
    logic              found_s;
    logic              hit_s;

    // Scan requesters in rotating order starting just after the last winner.
    always_comb begin
        gnt     = {NUM_PORTS{1'b0}};
        win_s   = last_r;
        found_s = 1'b0;
        hit_s   = 1'b0;
        sum_s   = {SUM_W{1'b0}};
        idx_s   = {PORT_W{1'b0}};
        for (int i = 1; i <= NUM_PORTS; i++) begin
            sum_s      = {1'b0, last_r} + SUM_W'(i);
            idx_s      = (sum_s >= SUM_W'(NUM_PORTS)) ? PORT_W'(sum_s - SUM_W'(NUM_PORTS))
                                                      : sum_s[PORT_W-1:0];
            hit_s      = advance & ~found_s & req[idx_s];
            gnt[idx_s] = gnt[idx_s] | hit_s;
            win_s      = hit_s ? idx_s : win_s;
            found_s    = found_s | hit_s;
        end
    end

    // Remember the winner; reset leaves input 0 first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= PORT_W'(NUM_PORTS - 1);
        end else if (found_s) begin
            last_r <= win_s;
        end else begin
            last_r <= last_r;
        end
    end
endmodule

// File: rtl/router_mesh_param.sv
// Five-port XY mesh router: per-input FIFOs, XY route on the FIFO head, one arbiter per output.
module router_mesh_param
    import router_pkg::*;
#(
    parameter int                   DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                   FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int                   X_BITS     = 1,
    parameter int                   Y_BITS     = 2,
    parameter int                   DST_LSB    = 0,
    parameter int                   MY_X       = 0,
    parameter int                   MY_Y       = 0,
    parameter logic [NUM_PORTS-1:0] PORT_EN    = 5'b11111
) (
    input logic                clk,
    input logic                rst_n,
    router_mesh_param_if.slave bus
);
    localparam int                PTR_W  = $clog2(FIFO_DEPTH);
    localparam int                CNT_W  = PTR_W + 1;
    localparam logic [X_BITS-1:0] MY_X_V = X_BITS'(MY_X);
    localparam logic [Y_BITS-1:0] MY_Y_V = Y_BITS'(MY_Y);

    logic [DATA_WIDTH-1:0]           mem_r     [NUM_PORTS][FIFO_DEPTH];
    logic [PTR_W-1:0]                wr_ptr_r  [NUM_PORTS];
    logic [PTR_W-1:0]                rd_ptr_r  [NUM_PORTS];
    logic [CNT_W-1:0]                cnt_r     [NUM_PORTS];
    logic [CNT_W-1:0]                cnt_nxt_s [NUM_PORTS];
    logic [NUM_PORTS-1:0]            full_r;
    logic [NUM_PORTS-1:0]            push_s;
    logic [NUM_PORTS-1:0]            pop_s;
    logic [NUM_PORTS-1:0]            avail_s;
    logic [NUM_PORTS-1:0]            misroute_s;
    logic [DATA_WIDTH-1:0]           head_s    [NUM_PORTS];
    logic [X_BITS-1:0]               dst_x_s   [NUM_PORTS];
    logic [Y_BITS-1:0]               dst_y_s   [NUM_PORTS];
    port_e                           route_s   [NUM_PORTS];
    logic [NUM_PORTS-1:0]            req_s     [NUM_PORTS];
    logic [NUM_PORTS-1:0]            gnt_s     [NUM_PORTS];
    logic [DATA_WIDTH-1:0]           sel_s     [NUM_PORTS];
    logic [NUM_PORTS*DATA_WIDTH-1:0] out_data_r;
    logic [NUM_PORTS-1:0]            out_valid_r;
    logic                            err_r;

    // Accept writes, and XY-route whatever sits at the head of each FIFO.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            push_s[p]  = bus.in_valid[p] & PORT_EN[p] & (cnt_r[p] != CNT_W'(FIFO_DEPTH));
            avail_s[p] = PORT_EN[p] & (cnt_r[p] != {CNT_W{1'b0}});
            head_s[p]  = mem_r[p][rd_ptr_r[p]];
            dst_x_s[p] = head_s[p][DST_LSB +: X_BITS];
            dst_y_s[p] = head_s[p][DST_LSB + X_BITS +: Y_BITS];
            if (dst_x_s[p] > MY_X_V) begin
                route_s[p] = PORT_EAST;
            end else if (dst_x_s[p] < MY_X_V) begin
                route_s[p] = PORT_WEST;
            end else if (dst_y_s[p] > MY_Y_V) begin
                route_s[p] = PORT_NORTH;
            end else if (dst_y_s[p] < MY_Y_V) begin
                route_s[p] = PORT_SOUTH;
            end else begin
                route_s[p] = PORT_LOCAL;
            end
            misroute_s[p] = avail_s[p] & ~PORT_EN[route_s[p]];
        end
    end

    // Request matrix indexed [output][input]; a head bound for a disabled port requests nothing.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                req_s[o][p] = avail_s[p] & PORT_EN[route_s[p]] & (route_s[p] == PORT_W'(o));
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
        rr_arbiter u_arb (
            .clk     (clk),
            .rst_n   (rst_n),
            .req     (req_s[o]),
            .advance (PORT_EN[o] & ~bus.out_full[o]),
            .gnt     (gnt_s[o])
        );
    end

    // Pops come from grants or misroute discards; pick the granted head for each output.
    always_comb begin
        pop_s = misroute_s;
        for (int o = 0; o < NUM_PORTS; o++) begin
            sel_s[o] = {DATA_WIDTH{1'b0}};
            for (int p = 0; p < NUM_PORTS; p++) begin
                pop_s[p] = pop_s[p] | gnt_s[o][p];
                sel_s[o] = sel_s[o] | (head_s[p] & {DATA_WIDTH{gnt_s[o][p]}});
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            cnt_nxt_s[p] = cnt_r[p] + CNT_W'(push_s[p]) - CNT_W'(pop_s[p]);
        end
    end

    // FIFO pointers, occupancy and the registered full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                wr_ptr_r[p] <= {PTR_W{1'b0}};
                rd_ptr_r[p] <= {PTR_W{1'b0}};
                cnt_r[p]    <= {CNT_W{1'b0}};
            end
            full_r <= {NUM_PORTS{1'b0}};
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                wr_ptr_r[p] <= wr_ptr_r[p] + PTR_W'(push_s[p]);
                rd_ptr_r[p] <= rd_ptr_r[p] + PTR_W'(pop_s[p]);
                cnt_r[p]    <= cnt_nxt_s[p];
                full_r[p]   <= (cnt_nxt_s[p] == CNT_W'(FIFO_DEPTH));
            end
        end
    end

    // FIFO storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (push_s[p]) begin
                mem_r[p][wr_ptr_r[p]] <= bus.in_data[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Output stage: one-cycle valid with data forced to zero when nothing was granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= {(NUM_PORTS*DATA_WIDTH){1'b0}};
            out_valid_r <= {NUM_PORTS{1'b0}};
            err_r       <= 1'b0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                out_data_r[o*DATA_WIDTH +: DATA_WIDTH] <= sel_s[o];
                out_valid_r[o]                         <= |gnt_s[o];
            end
            err_r <= |misroute_s;
        end
    end

    assign bus.in_full      = full_r | ~PORT_EN;
    assign bus.out_data     = out_data_r;
    assign bus.out_valid    = out_valid_r;
    assign bus.err_misroute = err_r;
endmodule

// File: tb/tb_router_mesh_param.sv
// Randomised and directed scoreboard bench for router_mesh_param (full mesh and border variant).
module tb_router_mesh_param;
    import router_pkg::*;

    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    router_mesh_param_if #(.DATA_WIDTH(DW)) bus_a ();
    router_mesh_param_if #(.DATA_WIDTH(DW)) bus_b ();

    router_mesh_param #(.DATA_WIDTH(DW), .FIFO_DEPTH(8), .X_BITS(1), .Y_BITS(2), .DST_LSB(0),
                        .MY_X(0), .MY_Y(0), .PORT_EN(5'b11111))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

    router_mesh_param #(.DATA_WIDTH(DW), .FIFO_DEPTH(8), .X_BITS(1), .Y_BITS(2), .DST_LSB(0),
                        .MY_X(0), .MY_Y(0), .PORT_EN(5'b00111))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    int vectors     = 0;
    int miscompares = 0;
    logic [DW-1:0] exp_q [25][$];    // keyed src*5 + output
    int src_log [$];
    int loc_cyc_log [$];
    int out_cnt [5];
    int mon_cyc = 0;
    int tag = 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Flit layout: [0] dst X, [2:1] dst Y, [5:3] source port, [31:8] unique tag.
    function automatic logic [DW-1:0] mk_flit(input int src, input int x, input int y, input int t);
        logic [DW-1:0] r;
        r        = {DW{1'b0}};
        r[0]     = x[0];
        r[2:1]   = y[1:0];
        r[5:3]   = src[2:0];
        r[31:8]  = t[23:0];
        return r;
    endfunction

    function automatic int ref_route(input int x, input int y, input int my_x, input int my_y);
        if (x > my_x) return 1;
        if (x < my_x) return 2;
        if (y > my_y) return 3;
        if (y < my_y) return 4;
        return 0;
    endfunction

    task automatic expect_flit(input int src, input logic [DW-1:0] f);
        exp_q[src*5 + ref_route(int'(f[0]), int'(f[2:1]), 0, 0)].push_back(f);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus_a.in_valid = 5'b0; bus_a.in_data = {(5*DW){1'b0}}; bus_a.out_full = 5'b0;
        bus_b.in_valid = 5'b0; bus_b.in_data = {(5*DW){1'b0}}; bus_b.out_full = 5'b0;
        for (int i = 0; i < 25; i++) exp_q[i].delete();
        src_log.delete();
        loc_cyc_log.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor for the full-mesh router: every valid output pops its (source, output) queue.
    logic [DW-1:0] mon_d;
    int            mon_s;
    always begin
        @(posedge clk);
        #1;
        mon_cyc++;
        if (rst_n) begin
            for (int o = 0; o < 5; o++) begin
                mon_d = bus_a.out_data[o*DW +: DW];
                if (bus_a.out_valid[o]) begin
                    mon_s = int'(mon_d[5:3]);
                    out_cnt[o]++;
                    if (o == 0) begin
                        src_log.push_back(mon_s);
                        loc_cyc_log.push_back(mon_cyc);
                    end
                    if (mon_s > 4 || exp_q[mon_s*5 + o].size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL sb_unexpected out%0d: got 0x%08h, expected no flit", o, mon_d);
                    end else begin
                        check($sformatf("sb_out%0d", o), mon_d, exp_q[mon_s*5 + o].pop_front());
                    end
                end else begin
                    check($sformatf("idle_data_out%0d", o), mon_d, {DW{1'b0}});
                end
            end
        end
    end

    logic [DW-1:0] f, g;
    logic [4:0]    rv;
    int            base, total, pulses, remaining;

    initial begin
        bus_a.in_valid = 5'b0; bus_a.in_data = {(5*DW){1'b0}}; bus_a.out_full = 5'b0;
        bus_b.in_valid = 5'b0; bus_b.in_data = {(5*DW){1'b0}}; bus_b.out_full = 5'b0;
        for (int o = 0; o < 5; o++) out_cnt[o] = 0;
        #1 rst_n = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", bus_a.out_valid, 5'b0);
        check("rst_out_data_lo", bus_a.out_data[DW-1:0], {DW{1'b0}});
        check("rst_err", bus_a.err_misroute, 1'b0);
        check("rst_in_full_a", bus_a.in_full, 5'b00000);
        check("rst_in_full_b", bus_b.in_full, 5'b11000);
        @(negedge clk);
        rst_n = 1'b1;

        // Single flit local -> east, two-edge latency
        do_reset();
        f = mk_flit(0, 1, 0, tag); tag++;
        bus_a.in_data[0 +: DW] = f; bus_a.in_valid = 5'b00001;
        expect_flit(0, f);
        @(posedge clk); #1;
        check("lat_edge1_valid", bus_a.out_valid[1], 1'b0);
        @(negedge clk); bus_a.in_valid = 5'b0;
        @(posedge clk); #1;
        check("lat_edge2_valid", bus_a.out_valid[1], 1'b1);
        check("lat_edge2_data", bus_a.out_data[DW +: DW], f);
        check("lat_err", bus_a.err_misroute, 1'b0);
        repeat (3) @(negedge clk);

        // Round robin on the local output across inputs 1..3
        do_reset();
        for (int i = 0; i < 4; i++) begin
            for (int p = 1; p <= 3; p++) begin
                f = mk_flit(p, 0, 0, tag); tag++;
                bus_a.in_data[p*DW +: DW] = f;
                expect_flit(p, f);
            end
            bus_a.in_valid = 5'b01110;
            @(negedge clk);
        end
        bus_a.in_valid = 5'b0;
        repeat (20) @(negedge clk);
        check("rr_count", src_log.size(), 12);
        for (int i = 0; i < src_log.size() && i < 12; i++)
            check($sformatf("rr_order_%0d", i), src_log[i], 1 + (i % 3));
        if (loc_cyc_log.size() >= 12)
            check("rr_consecutive", loc_cyc_log[11] - loc_cyc_log[0], 11);

        // Back-pressure: FIFO fills at 8, 9th write dropped, 8 drain in order
        do_reset();
        base = out_cnt[1];
        bus_a.out_full = 5'b00010;
        for (int i = 0; i < 9; i++) begin
            f = mk_flit(0, 1, 0, tag); tag++;
            bus_a.in_data[0 +: DW] = f; bus_a.in_valid = 5'b00001;
            if (i < 8) expect_flit(0, f);
            @(posedge clk); #1;
            check($sformatf("full_after_%0d", i + 1), bus_a.in_full[0], logic'(i >= 7));
            @(negedge clk);
        end
        bus_a.in_valid = 5'b0;
        @(negedge clk);
        check("blocked_no_output", out_cnt[1] - base, 0);
        bus_a.out_full = 5'b0;
        repeat (15) @(negedge clk);
        check("drain_count", out_cnt[1] - base, 8);
        check("drain_not_full", bus_a.in_full[0], 1'b0);

        // Reset mid-operation discards buffered flits
        do_reset();
        bus_a.out_full = 5'b00010;
        for (int i = 0; i < 5; i++) begin
            f = mk_flit(0, 1, 0, tag); tag++;
            bus_a.in_data[0 +: DW] = f; bus_a.in_valid = 5'b00001;
            @(negedge clk);
        end
        bus_a.in_valid = 5'b0;
        do_reset();
        check("mid_rst_in_full", bus_a.in_full, 5'b0);
        total = out_cnt[0] + out_cnt[1] + out_cnt[2] + out_cnt[3] + out_cnt[4];
        repeat (3) @(negedge clk);
        check("mid_rst_quiet", out_cnt[0] + out_cnt[1] + out_cnt[2] + out_cnt[3] + out_cnt[4] - total, 0);
        f = mk_flit(0, 1, 0, tag); tag++;
        bus_a.in_data[0 +: DW] = f; bus_a.in_valid = 5'b00001;
        expect_flit(0, f);
        @(posedge clk); #1;
        check("mid_rst_lat1", bus_a.out_valid[1], 1'b0);
        @(negedge clk); bus_a.in_valid = 5'b0;
        @(posedge clk); #1;
        check("mid_rst_lat2", bus_a.out_valid[1], 1'b1);
        check("mid_rst_data", bus_a.out_data[DW +: DW], f);
        repeat (3) @(negedge clk);

        // Border router: misroute to disabled north, ignored disabled input, legal east flit
        do_reset();
        check("b_in_full", bus_b.in_full, 5'b11000);
        f = mk_flit(0, 0, 2, tag); tag++;
        g = mk_flit(2, 1, 0, tag); tag++;
        bus_b.in_data[0 +: DW]    = f;
        bus_b.in_data[2*DW +: DW] = g;
        bus_b.in_data[3*DW +: DW] = mk_flit(3, 0, 0, tag); tag++;
        bus_b.in_valid = 5'b01101;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            pulses += int'(bus_b.err_misroute);
            check($sformatf("b_err_c%0d", c), bus_b.err_misroute, logic'(c == 1));
            check($sformatf("b_out_valid_c%0d", c), bus_b.out_valid, (c == 1) ? 5'b00010 : 5'b00000);
            if (c == 1) check("b_east_data", bus_b.out_data[DW +: DW], g);
            check($sformatf("b_local_data_c%0d", c), bus_b.out_data[0 +: DW], {DW{1'b0}});
            @(negedge clk);
            bus_b.in_valid = 5'b0;
        end
        check("b_err_pulses", pulses, 1);
        check("b_in_full_end", bus_b.in_full, 5'b11000);

        // Random traffic with random back-pressure
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rv = 5'b0;
            for (int p = 0; p < 5; p++) begin
                if ($urandom_range(0, 1) == 1 && !bus_a.in_full[p]) begin
                    f = mk_flit(p, $urandom_range(0, 1), $urandom_range(0, 3), tag); tag++;
                    bus_a.in_data[p*DW +: DW] = f;
                    rv[p] = 1'b1;
                    expect_flit(p, f);
                end
            end
            bus_a.in_valid = rv;
            bus_a.out_full = 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31));
            @(negedge clk);
        end
        bus_a.in_valid = 5'b0;
        bus_a.out_full = 5'b0;
        repeat (60) @(negedge clk);
        remaining = 0;
        for (int i = 0; i < 25; i++) remaining += exp_q[i].size();
        check("sb_drain_empty", remaining, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/router_mesh_param.md
ROUTER_MESH_PARAM -- requirements
Module: router_mesh_param

Interface
REQ-001 Parameter DATA_WIDTH, 32, flit width in bits.
REQ-002 Parameter FIFO_DEPTH, 8, input FIFO entries per port (power of 2, at least 2).
REQ-003 Parameter X_BITS, 1, width of the destination X coordinate.
REQ-004 Parameter Y_BITS, 2, width of the destination Y coordinate.
REQ-005 Parameter DST_LSB, 0, LSB of the destination field; flit[DST_LSB +: X_BITS] is X, the next Y_BITS bits are Y.
REQ-006 Parameters MY_X and MY_Y, both 0, this router's coordinates.
REQ-007 Parameter PORT_EN, 5'b11111, per-port enable mask; clear bits build border and corner routers.
REQ-008 clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-009 in_data  in  5*DATA_WIDTH  flit per input port, port p at [p*DATA_WIDTH +: DATA_WIDTH].
REQ-010 in_valid  in  5  write strobe per input port.
REQ-011 in_full  out  5  input FIFO full per port.
REQ-012 out_data  out  5*DATA_WIDTH  registered flit per output port.
REQ-013 out_valid  out  5  registered one-cycle valid per output port.
REQ-014 out_full  in  5  downstream full per output port.
REQ-015 err_misroute  out  1  one-cycle pulse when a flit is discarded because its route selects a disabled port.

Function
REQ-016 Port indices SHALL be 0 local, 1 east (+X), 2 west (-X), 3 north (+Y), 4 south (-Y).
REQ-017 Each enabled input SHALL have a synchronous FIFO of FIFO_DEPTH entries; in_full[p] = (count == FIFO_DEPTH).
REQ-018 A write while full SHALL be dropped, even if a pop occurs in the same cycle; a flit written into an empty FIFO is not poppable in the same cycle.
REQ-019 Route compute on the FIFO head SHALL be XY-ordered: dst X > MY_X gives east, dst X < MY_X gives west, else dst Y > MY_Y gives north, dst Y < MY_Y gives south, else local; comparisons are unsigned.
REQ-020 Each output SHALL have a round-robin arbiter over the inputs requesting it; the highest priority goes to the input after the last granted one; the pointer updates only on a grant.
REQ-021 An output SHALL grant only when out_full[o] is 0 in that cycle; a granted input pops its FIFO in that same cycle.
REQ-022 A granted flit SHALL appear on out_data[o] with out_valid[o]=1 on the next edge; with no grant, out_valid[o]=0 and out_data[o]=0.
REQ-023 Latency with no contention: a flit written at edge k SHALL be output-valid after edge k+2.
REQ-024 Each input requests exactly one output per cycle; different outputs grant independently, so up to 5 flits SHALL move per cycle.
REQ-025 A head routed to a disabled output SHALL be popped without arbitration, and err_misroute SHALL pulse on the next edge.
REQ-026 For a disabled port p: in_full[p]=1, in_valid[p] and in_data[p] are ignored, and out_valid[p]=0 and out_data[p]=0 permanently.
REQ-027 A U-turn (output equal to input, non-local) SHALL be legal and arbitrated normally.

Reset
REQ-028 While rst_n=0, all FIFO pointers and counts SHALL be 0, out_valid=0, out_data=0, err_misroute=0, and every arbiter pointer SHALL give input 0 highest priority.
REQ-029 Reset asserted mid-operation SHALL discard all buffered flits; in_full of enabled ports is 0 from the first cycle after deassertion.

Structure
REQ-030 Package router_pkg SHALL hold the port index constants, NUM_PORTS=5, and the default DATA_WIDTH and FIFO_DEPTH.
REQ-031 One sub-module, rr_arbiter (5 requests, one-hot grant, advance input), SHALL be instantiated once per output; FIFO and route compute stay inline.

Verification
REQ-032 MY=(0,0); local writes flit dst (1,0) at edge 0 -> out_valid[1]=1 with the same data after edge 2; err_misroute stays 0.
REQ-033 Inputs 1, 2, 3 each hold 4 flits to local, all with out_full=0 -> local output grants inputs 1,2,3,1,2,3,... on consecutive cycles, 12 valid cycles total.
REQ-034 out_full[1] held at 1 for 10 cycles while local pushes 9 flits east -> in_full[0]=1 after the 8th flit, the 9th is dropped, and after release 8 flits emerge in order.
REQ-035 PORT_EN=5'b00111, MY=(0,0); local writes a flit with dst (0,2) -> flit discarded, err_misroute pulses once, out_valid all 0, in_full[3]=in_full[4]=1.
REQ-036 rst_n pulsed low while FIFO 0 holds 5 flits -> after deassertion no out_valid for 3 cycles, and a new flit has 2-cycle latency.
